axi4_wr_order_ctrl: RTL and testbench
=====================================

Name: axi4_wr_order_ctrl

Overview:
- Write-channel sequencer between the CPU BIU master port and the pad-side AXI slave.
- Fronts the 32-entry AW-order WID FIFO.
- Throttles AW when 32 write bursts are outstanding, so the WID FIFO can never overflow.
- Holds off W until its AW has been accepted.
- Checks each W burst's beat count against the captured AWLEN and flags WLAST violations.

Parameters:
- DEPTH, 32, max outstanding write bursts; must equal the WID FIFO depth; power of two.
- PTR_W, 5, log2(DEPTH).
- LEN_W, 8, AWLEN width (AXI4).

Ports:
- per_clk  in  1  clock
- pad_cpu_rst_b  in  1  async reset, active-low
- m_awvalid  in  1  BIU AW valid
- m_awready  out  1  AW ready to BIU
- m_awlen  in  LEN_W  burst length minus 1
- s_awvalid  out  1  AW valid to pad
- s_awready  in  1  pad AW ready
- m_wvalid  in  1  BIU W valid
- m_wlast  in  1  BIU W last
- m_wready  out  1  W ready to BIU
- s_wvalid  out  1  W valid to pad
- s_wready  in  1  pad W ready
- err_clr  in  1  clears the sticky error
- ost_cnt  out  PTR_W+1  outstanding bursts, 0..DEPTH
- full  out  1  ost_cnt==DEPTH
- empty  out  1  ost_cnt==0
- wlast_err  out  1  sticky WLAST/beat-count mismatch

Behaviour:
- Reset is asynchronous on pad_cpu_rst_b low. All state clears:
  - ost_cnt=0, full=0, empty=1, wlast_err=0.
  - beat_cnt=0, FSM=W_IDLE.
  - Length-FIFO pointers = 0.
- A reset mid-burst discards all outstanding entries.
- AW path (combinational, zero latency):
  - s_awvalid = m_awvalid & ~full.
  - m_awready = s_awready & ~full.
  - aw_fire = m_awvalid & s_awready & ~full.
  - aw_fire pushes m_awlen into the length FIFO at wr_ptr; wr_ptr wraps modulo DEPTH.
- W gating uses registered signals:
  - w_en = (FSM==W_ACTIVE).
  - s_wvalid = m_wvalid & w_en.
  - m_wready = s_wready & w_en.
  - w_fire = m_wvalid & s_wready & w_en.
- W is therefore enabled no earlier than the cycle after the first aw_fire (1-cycle AW->W latency).
- FSM:
  - W_IDLE -> W_ACTIVE when ~empty.
  - W_ACTIVE -> W_IDLE when pop occurs and the post-pop count is 0.
  - W_ACTIVE stays W_ACTIVE on pop with entries remaining, and on a simultaneous push that keeps the count above 0.
- Pop and beat counting:
  - pop = w_fire & m_wlast. Advances rd_ptr (wraps) and resets beat_cnt to 0.
  - Pop semantics are identical to the WID FIFO pop, so both FIFOs stay aligned.
  - On w_fire & ~m_wlast, beat_cnt increments, saturating at 2^LEN_W-1.
  - exp_last = (beat_cnt == head_len), where head_len = length-FIFO entry at rd_ptr.
- Error detection: on w_fire, if m_wlast != exp_last, wlast_err sets on the next edge.
  - The pop still follows m_wlast; the error never alters the handshake.
- wlast_err is sticky until err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- Counter update:
  - aw_fire & ~pop: ost_cnt+1.
  - pop & ~aw_fire: ost_cnt-1.
  - Both or neither: unchanged.
- Simultaneous events:
  - Push while full cannot occur (gated).
  - Pop while empty cannot occur (w_en=0).
  - Push and pop while full: the push is blocked by ~full, so only the pop takes effect.
- full and empty are decoded from registered ost_cnt.
- The block has no combinational path from s_awready to s_wvalid.

Decomposition:
- Package axi4_wr_pkg: DEPTH, PTR_W, LEN_W constants; FSM state enum {W_IDLE, W_ACTIVE}.
- Sub-module axi4_wr_len_fifo: DEPTH x LEN_W register array.
  - Push/pop pointers, wrapping.
  - Asynchronous-read head output.
- Top-level: AW/W gating, FSM, beat counter, ost_cnt, error logic.

Test Plan:
- Single burst: AW awlen=3 accepted at cycle 0 -> s_wvalid stays 0 at cycle 0, W enabled at cycle 1; 4 beats with wlast on the 4th -> pop, ost_cnt 1->0, empty=1, wlast_err=0.
- Fill: 32 AW accepts with W held off -> full=1 and m_awready=0 with s_awready=1; 33rd AW stalled. One W burst completes -> full=0, and the 33rd AW fires on the next cycle.
- Simultaneous: ost_cnt=5, aw_fire and pop in the same cycle -> ost_cnt stays 5; the FIFO head advances to the next awlen.
- Pointer wrap: 40 sequential single-beat bursts (awlen=0) with mixed lengths pushed behind -> every burst checks clean, wlast_err=0.
- Errors:
  - awlen=2 with wlast on beat 2 -> wlast_err=1 on the next edge, ost_cnt decrements.
  - awlen=1 with wlast missing on beat 2 -> error set.
  - err_clr pulse -> wlast_err=0.
- Reset mid-burst: 3 outstanding bursts, 2 beats in; assert pad_cpu_rst_b=0 -> ost_cnt=0, empty=1, s_wvalid=0 immediately; after release a fresh burst passes clean.

Source files
------------

// File: rtl/axi4_wr_pkg.sv
// Shared constants and types for the AXI4 write-order controller.
//   DEPTH : max outstanding write bursts (matches the WID FIFO depth)
//   PTR_W : log2(DEPTH)
//   LEN_W : AWLEN width
//   w_state_e : W-channel gating FSM states
package axi4_wr_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned PTR_W = 5;
  localparam int unsigned LEN_W = 8;

  typedef enum logic [0:0] {
    W_IDLE,
    W_ACTIVE
  } w_state_e;

endpackage

// File: rtl/axi4_wr_len_fifo.sv
// AW-order length FIFO: records AWLEN of every accepted AW so the W channel
// can check beat counts. Pops in lock-step with the external WID FIFO.
// Ports:
//   per_clk, pad_cpu_rst_b : clock, async active-low reset (clears pointers)
//   push, push_len         : write push_len at the write pointer
//   pop                    : advance the read pointer
//   head_len               : entry at the read pointer (asynchronous read)
// Occupancy is tracked by the parent; pushes while full never arrive here.
module axi4_wr_len_fifo
  import axi4_wr_pkg::*;
(
  input  logic             per_clk,
  input  logic             pad_cpu_rst_b,
  input  logic             push,
  input  logic [LEN_W-1:0] push_len,
  input  logic             pop,
  output logic [LEN_W-1:0] head_len
);

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge per_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_len;
  end

  assign head_len = mem_q[rd_ptr_q];

endmodule

// File: rtl/axi4_wr_order_ctrl.sv
// Write-channel sequencer between the BIU master port and the pad AXI slave.
// Throttles AW at DEPTH outstanding bursts, holds W off until its AW has
// been accepted, and flags bursts whose WLAST disagrees with the captured AWLEN.
// Ports:
//   per_clk, pad_cpu_rst_b          : clock, async active-low reset
//   m_awvalid/m_awready/m_awlen     : AW from BIU
//   s_awvalid/s_awready             : AW to pad
//   m_wvalid/m_wlast/m_wready       : W from BIU
//   s_wvalid/s_wready               : W to pad
//   err_clr                         : clears wlast_err
//   ost_cnt, full, empty            : outstanding burst count and its decodes
//   wlast_err                       : sticky WLAST/beat-count mismatch
module axi4_wr_order_ctrl
  import axi4_wr_pkg::*;
(
  input  logic             per_clk,
  input  logic             pad_cpu_rst_b,
  input  logic             m_awvalid,
  output logic             m_awready,
  input  logic [LEN_W-1:0] m_awlen,
  output logic             s_awvalid,
  input  logic             s_awready,
  input  logic             m_wvalid,
  input  logic             m_wlast,
  output logic             m_wready,
  output logic             s_wvalid,
  input  logic             s_wready,
  input  logic             err_clr,
  output logic [PTR_W:0]   ost_cnt,
  output logic             full,
  output logic             empty,
  output logic             wlast_err
);

  localparam int unsigned CntW = PTR_W + 1;

  w_state_e         state_q, state_d;
  logic [CntW-1:0]  ost_cnt_q, ost_cnt_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             wlast_err_q, wlast_err_d;
  logic [LEN_W-1:0] head_len;
  logic             aw_fire, w_en, w_fire, pop, exp_last, err_set;

  assign full  = (ost_cnt_q == CntW'(DEPTH));
  assign empty = (ost_cnt_q == '0);

  // AW path is purely combinational; full comes from a register.
  assign s_awvalid = m_awvalid & ~full;
  assign m_awready = s_awready & ~full;
  assign aw_fire   = m_awvalid & s_awready & ~full;

  // W gating depends only on the registered FSM state.
  assign w_en     = (state_q == W_ACTIVE);
  assign s_wvalid = m_wvalid & w_en;
  assign m_wready = s_wready & w_en;
  assign w_fire   = m_wvalid & s_wready & w_en;
  assign pop      = w_fire & m_wlast;

  assign exp_last = (beat_cnt_q == head_len);
  assign err_set  = w_fire & (m_wlast != exp_last);

  axi4_wr_len_fifo u_len_fifo (
    .per_clk       (per_clk),
    .pad_cpu_rst_b (pad_cpu_rst_b),
    .push          (aw_fire),
    .push_len      (m_awlen),
    .pop           (pop),
    .head_len      (head_len)
  );

  always_comb begin
    ost_cnt_d = ost_cnt_q;
    unique case ({aw_fire, pop})
      2'b10:   ost_cnt_d = ost_cnt_q + CntW'(1);
      2'b01:   ost_cnt_d = ost_cnt_q - CntW'(1);
      default: ost_cnt_d = ost_cnt_q;
    endcase
  end

  // Transitions look at the next count so W opens the cycle after the first
  // AW handshake rather than two cycles later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE:   if (ost_cnt_d != '0) state_d = W_ACTIVE;
      W_ACTIVE: if (pop && ost_cnt_d == '0) state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = '0;
    end else if (w_fire && beat_cnt_q != '1) begin
      beat_cnt_d = beat_cnt_q + LEN_W'(1);
    end
  end

  // A new error wins over a same-cycle clear.
  always_comb begin
    wlast_err_d = wlast_err_q;
    if (err_set)      wlast_err_d = 1'b1;
    else if (err_clr) wlast_err_d = 1'b0;
  end

  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q     <= W_IDLE;
      ost_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ost_cnt_q   <= ost_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign ost_cnt   = ost_cnt_q;
  assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_axi4_wr_order_ctrl.sv
module tb_axi4_wr_order_ctrl;
  import axi4_wr_pkg::*;

  logic             per_clk = 1'b0;
  logic             pad_cpu_rst_b;
  logic             m_awvalid, m_awready, s_awvalid, s_awready;
  logic [LEN_W-1:0] m_awlen;
  logic             m_wvalid, m_wlast, m_wready, s_wvalid, s_wready;
  logic             err_clr;
  logic [PTR_W:0]   ost_cnt;
  logic             full, empty, wlast_err;

  always #5 per_clk = ~per_clk;

  axi4_wr_order_ctrl dut (
    .per_clk       (per_clk),
    .pad_cpu_rst_b (pad_cpu_rst_b),
    .m_awvalid     (m_awvalid),
    .m_awready     (m_awready),
    .m_awlen       (m_awlen),
    .s_awvalid     (s_awvalid),
    .s_awready     (s_awready),
    .m_wvalid      (m_wvalid),
    .m_wlast       (m_wlast),
    .m_wready      (m_wready),
    .s_wvalid      (s_wvalid),
    .s_wready      (s_wready),
    .err_clr       (err_clr),
    .ost_cnt       (ost_cnt),
    .full          (full),
    .empty         (empty),
    .wlast_err     (wlast_err)
  );

  typedef enum int {SigCnt, SigFull, SigEmpty, SigErr, SigMAwRdy, SigSAwVld, SigSWVld, SigMWRdy}
    sig_e;
  typedef struct {
    string name;
    sig_e  sig;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];   // model of the AW-order length FIFO
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic int sample(sig_e s);
    case (s)
      SigCnt:    return int'(ost_cnt);
      SigFull:   return int'(full);
      SigEmpty:  return int'(empty);
      SigErr:    return int'(wlast_err);
      SigMAwRdy: return int'(m_awready);
      SigSAwVld: return int'(s_awvalid);
      SigSWVld:  return int'(s_wvalid);
      default:   return int'(m_wready);
    endcase
  endfunction

  // Monitor: compares every queued expectation against the DUT outputs on the
  // falling edge, away from the active edge.
  always @(negedge per_clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      int   act;
      e   = exp_q.pop_front();
      act = sample(e.sig);
      n_checks++;
      if (act != e.val) begin
        n_errors++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.val, $time);
      end
    end
  end

  task automatic chk(input string n, input sig_e s, input int v);
    exp_q.push_back('{name: n, sig: s, val: v});
  endtask

  task automatic cyc();
    @(posedge per_clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input int err);
    chk({tag, "_cnt"}, SigCnt, cnt);
    chk({tag, "_full"}, SigFull, int'(cnt == DEPTH));
    chk({tag, "_empty"}, SigEmpty, int'(cnt == 0));
    chk({tag, "_err"}, SigErr, err);
  endtask

  // One accepted AW; requires the controller not to be full.
  task automatic aw_push(input int len);
    m_awvalid = 1'b1;
    m_awlen   = LEN_W'(len);
    chk("aw_ready", SigMAwRdy, 1);
    chk("aw_svalid", SigSAwVld, 1);
    cyc();
    m_awvalid = 1'b0;
    len_q.push_back(len);
  endtask

  // A well-formed W burst of len+1 beats.
  task automatic w_burst(input int len);
    for (int b = 0; b <= len; b++) begin
      m_wvalid = 1'b1;
      m_wlast  = (b == len);
      chk("w_ready", SigMWRdy, 1);
      chk("w_svalid", SigSWVld, 1);
      cyc();
    end
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
  endtask

  task automatic drain();
    while (len_q.size() > 0) w_burst(len_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    pad_cpu_rst_b = 1'b0;
    m_awvalid = 1'b0; m_awlen = '0; s_awready = 1'b1;
    m_wvalid  = 1'b1; m_wlast = 1'b0; s_wready = 1'b1;
    err_clr   = 1'b0;
    #1;
    // Reset state, with W valid held to prove the gate is closed.
    chk_state("rst", 0, 0);
    chk("rst_swvalid", SigSWVld, 0);
    chk("rst_wready", SigMWRdy, 0);
    cyc(); cyc();
    pad_cpu_rst_b = 1'b1;
    cyc();

    // Single burst: W closed in the AW cycle, open the next.
    m_awvalid = 1'b1; m_awlen = 8'd3; m_wvalid = 1'b1;
    chk("single_c0_awready", SigMAwRdy, 1);
    chk("single_c0_swvalid", SigSWVld, 0);
    cyc();
    m_awvalid = 1'b0;
    chk_state("single_c1", 1, 0);
    chk("single_c1_swvalid", SigSWVld, 1);
    w_burst(3);
    m_wvalid = 1'b1;
    chk_state("single_done", 0, 0);
    chk("single_done_swvalid", SigSWVld, 0);
    cyc();
    m_wvalid = 1'b0;

    // Fill to DEPTH with W held off; first burst is single-beat.
    for (int i = 0; i < DEPTH; i++) aw_push(i % 3);
    m_awvalid = 1'b1; m_awlen = 8'd2;
    chk_state("fill", 32, 0);
    chk("fill_awready", SigMAwRdy, 0);
    chk("fill_savalid", SigSAwVld, 0);
    cyc();
    chk("fill_stall_awready", SigMAwRdy, 0);
    chk("fill_stall_cnt", SigCnt, 32);
    m_wvalid = 1'b1; m_wlast = 1'b1;
    cyc();
    void'(len_q.pop_front());
    m_wvalid = 1'b0; m_wlast = 1'b0;
    chk_state("fill_pop", 31, 0);
    chk("fill_33_awready", SigMAwRdy, 1);
    chk("fill_33_savalid", SigSAwVld, 1);
    cyc();
    len_q.push_back(2);
    m_awvalid = 1'b0;
    chk_state("fill_33", 32, 0);
    drain();
    chk_state("fill_drained", 0, 0);

    // Simultaneous push and pop at ost_cnt=5.
    aw_push(1); aw_push(2); aw_push(0); aw_push(3); aw_push(1);
    chk("sim_pre_cnt", SigCnt, 5);
    m_wvalid = 1'b1; m_wlast = 1'b0;
    cyc();
    m_wlast = 1'b1; m_awvalid = 1'b1; m_awlen = 8'd2;
    chk("sim_awready", SigMAwRdy, 1);
    cyc();
    void'(len_q.pop_front());
    len_q.push_back(2);
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_wlast = 1'b0;
    chk_state("sim_post", 5, 0);
    drain();   // head must now be 2, so a stale head would flag an error
    chk_state("sim_drained", 0, 0);

    // Pointer wrap: 40 pipelined single-beat bursts.
    for (int c = 0; c <= 40; c++) begin
      m_awvalid = (c < 40);
      m_awlen   = '0;
      m_wvalid  = (c > 0);
      m_wlast   = 1'b1;
      if (c == 20) chk("wrap_mid_cnt", SigCnt, 1);
      cyc();
    end
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_wlast = 1'b0;
    chk_state("wrap_done", 0, 0);

    // Error: awlen=2, wlast on beat 2.
    aw_push(2);
    m_wvalid = 1'b1; m_wlast = 1'b0;
    cyc();
    m_wlast = 1'b1;
    chk("err_early_pre", SigErr, 0);
    cyc();
    m_wvalid = 1'b0; m_wlast = 1'b0;
    len_q.delete();
    chk_state("err_early", 0, 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("err_clr1", SigErr, 0);

    // Error: awlen=1, wlast missing on beat 2, then late wlast on beat 3.
    aw_push(1);
    m_wvalid = 1'b1; m_wlast = 1'b0;
    cyc(); cyc();
    chk_state("err_missing", 1, 1);
    m_wlast = 1'b1;
    cyc();
    m_wvalid = 1'b0; m_wlast = 1'b0;
    len_q.delete();
    chk_state("err_late_pop", 0, 1);

    // Clear coinciding with a new error: set wins. Then a clean clear.
    aw_push(0);
    m_wvalid = 1'b1; m_wlast = 1'b0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("err_set_wins", SigErr, 1);
    m_wlast = 1'b1;
    cyc();
    m_wvalid = 1'b0; m_wlast = 1'b0;
    len_q.delete();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk_state("err_clr2", 0, 0);

    // Reset mid-burst: 3 outstanding, 2 beats into the first.
    aw_push(3); aw_push(3); aw_push(3);
    m_wvalid = 1'b1; m_wlast = 1'b0;
    cyc(); cyc();
    pad_cpu_rst_b = 1'b0;
    chk_state("midrst", 0, 0);
    chk("midrst_swvalid", SigSWVld, 0);
    cyc();
    len_q.delete();
    m_wvalid = 1'b0;
    pad_cpu_rst_b = 1'b1;
    cyc();
    aw_push(1);
    drain();
    chk_state("post_rst", 0, 0);

    cyc(); cyc();
    if (exp_q.size() != 0) begin
      $display("FAIL pending: got %0d unchecked expectations expected 0", exp_q.size());
      $fatal(1);
    end
    if (n_checks < 12) begin
      $display("FAIL coverage: got %0d checks expected at least 12", n_checks);
      $fatal(1);
    end
    if (n_errors != 0) begin
      $display("FAIL summary: got %0d errors expected 0", n_errors);
      $fatal(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
